// File: rtl/adc_frame_align_ctrl.sv
// ---------------------------------------------------------------------------
// adc_frame_align_ctrl
//
// Brings up the LVDS ADC receive path and aligns it to the frame clock.
// The SERDES/lane logic is held in reset until the DCLK MMCM reports lock.
// The controller then issues BITSLIP pulses until the deserialized FCLK word
// matches the frame pattern, and reports lock to the lane datapath. When
// alignment is lost, it retries with a bounded number of full reset attempts.
// Everything runs on the divided frame clock.
//
// Ports
//   FrmClkDiv   in   divided frame clock, rising edge
//   FrmRst_n    in   asynchronous active-low reset
//   MmcmLocked  in   DCLK MMCM lock (asynchronous, synchronized here)
//   ReAlign     in   one-cycle pulse that restarts alignment and clears RetryCnt
//   FrmWord     in   deserialized FCLK word, one per cycle
//   IntfRst     out  active-high reset to SERDES/lane logic
//   Bitslip     out  one-cycle BITSLIP pulse to the ISERDES blocks
//   AlignDone   out  frame alignment achieved and holding
//   AlignFail   out  all retries exhausted
//   SlipCnt     out  bitslips issued in the current attempt
//   RetryCnt    out  reset attempts since reset/ReAlign (saturates at 15)
// ---------------------------------------------------------------------------
module adc_frame_align_ctrl #(
    parameter int          AdcBits      = 12,
    parameter logic [15:0] FrmPattern   = 16'b0000111111000000,
    parameter int          RstCycles    = 16,
    parameter int          SettleCycles = 8,
    parameter int          StableWords  = 32,
    parameter int          LossWords    = 4,
    parameter int          MaxRetries   = 3
) (
    input  logic        FrmClkDiv,
    input  logic        FrmRst_n,
    input  logic        MmcmLocked,
    input  logic        ReAlign,
    input  logic [15:0] FrmWord,
    output logic        IntfRst,
    output logic        Bitslip,
    output logic        AlignDone,
    output logic        AlignFail,
    output logic [3:0]  SlipCnt,
    output logic [3:0]  RetryCnt
);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] RST_HOLD  = 3'd1;
    localparam logic [2:0] SETTLE    = 3'd2;
    localparam logic [2:0] CHECK     = 3'd3;
    localparam logic [2:0] SLIP      = 3'd4;
    localparam logic [2:0] LOCKED    = 3'd5;
    localparam logic [2:0] FAIL      = 3'd6;

    // Only the low AdcBits bits of each word carry frame information.
    localparam logic [15:0] CmpMask    = 16'((1 << AdcBits) - 1);
    localparam logic [7:0]  RstLast    = 8'(RstCycles - 1);
    localparam logic [7:0]  SettleLast = 8'(SettleCycles - 1);
    localparam logic [7:0]  StableLast = 8'(StableWords - 1);
    localparam logic [7:0]  LossLast   = 8'(LossWords - 1);
    localparam logic [3:0]  SlipMax    = 4'(AdcBits - 1);
    localparam logic [3:0]  RetryMax   = 4'(MaxRetries);

    logic [2:0] state;
    logic       mmcmMeta;
    logic       mmcmSync;
    logic       matchReg;
    logic [7:0] cycleCnt;
    logic [7:0] matchCnt;
    logic [7:0] lossCnt;
    logic       primed;
    logic [3:0] retrySat;

    assign retrySat = (RetryCnt == 4'hF) ? RetryCnt : RetryCnt + 4'd1;

    // Two-flop synchronizer for the MMCM lock, which comes from another domain.
    always_ff @(posedge FrmClkDiv or negedge FrmRst_n) begin
        if (!FrmRst_n) begin
            mmcmMeta <= 1'b0;
            mmcmSync <= 1'b0;
        end else begin
            mmcmMeta <= MmcmLocked;
            mmcmSync <= mmcmMeta;
        end
    end

    // Registered pattern compare; each word's result is seen one cycle later.
    always_ff @(posedge FrmClkDiv or negedge FrmRst_n) begin
        if (!FrmRst_n) begin
            matchReg <= 1'b0;
        end else begin
            matchReg <= ((FrmWord ^ FrmPattern) & CmpMask) == 16'd0;
        end
    end

    // Alignment sequencer. Outputs are registered alongside the state so that
    // they always reflect the state being entered. Lock loss overrides
    // everything, ReAlign overrides the normal flow. On entering CHECK the
    // first registered result still belongs to a SETTLE word, so it is
    // skipped (primed) and only words that arrive during CHECK are counted.
    always_ff @(posedge FrmClkDiv or negedge FrmRst_n) begin
        if (!FrmRst_n) begin
            state     <= WAIT_LOCK;
            IntfRst   <= 1'b1;
            Bitslip   <= 1'b0;
            AlignDone <= 1'b0;
            AlignFail <= 1'b0;
            SlipCnt   <= 4'd0;
            RetryCnt  <= 4'd0;
            cycleCnt  <= 8'd0;
            matchCnt  <= 8'd0;
            lossCnt   <= 8'd0;
            primed    <= 1'b0;
        end else begin
            Bitslip <= 1'b0;
            if (!mmcmSync) begin
                state     <= WAIT_LOCK;
                IntfRst   <= 1'b1;
                AlignDone <= 1'b0;
                AlignFail <= 1'b0;
                if (ReAlign) begin
                    RetryCnt <= 4'd0;
                end
            end else if (ReAlign) begin
                state     <= RST_HOLD;
                IntfRst   <= 1'b1;
                AlignDone <= 1'b0;
                AlignFail <= 1'b0;
                SlipCnt   <= 4'd0;
                RetryCnt  <= 4'd0;
                cycleCnt  <= 8'd0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        state    <= RST_HOLD;
                        IntfRst  <= 1'b1;
                        SlipCnt  <= 4'd0;
                        cycleCnt <= 8'd0;
                    end
                    RST_HOLD: begin
                        if (cycleCnt == RstLast) begin
                            state    <= SETTLE;
                            IntfRst  <= 1'b0;
                            cycleCnt <= 8'd0;
                        end else begin
                            cycleCnt <= cycleCnt + 8'd1;
                        end
                    end
                    SETTLE: begin
                        if (cycleCnt == SettleLast) begin
                            state    <= CHECK;
                            matchCnt <= 8'd0;
                            primed   <= 1'b0;
                        end else begin
                            cycleCnt <= cycleCnt + 8'd1;
                        end
                    end
                    CHECK: begin
                        if (!primed) begin
                            primed <= 1'b1;
                        end else if (matchReg) begin
                            if (matchCnt == StableLast) begin
                                state     <= LOCKED;
                                AlignDone <= 1'b1;
                                lossCnt   <= 8'd0;
                            end else begin
                                matchCnt <= matchCnt + 8'd1;
                            end
                        end else if (SlipCnt < SlipMax) begin
                            state   <= SLIP;
                            Bitslip <= 1'b1;
                            SlipCnt <= SlipCnt + 4'd1;
                        end else if (RetryCnt < RetryMax) begin
                            state    <= RST_HOLD;
                            IntfRst  <= 1'b1;
                            SlipCnt  <= 4'd0;
                            RetryCnt <= RetryCnt + 4'd1;
                            cycleCnt <= 8'd0;
                        end else begin
                            state     <= FAIL;
                            IntfRst   <= 1'b1;
                            AlignFail <= 1'b1;
                        end
                    end
                    SLIP: begin
                        state    <= SETTLE;
                        cycleCnt <= 8'd0;
                        matchCnt <= 8'd0;
                    end
                    LOCKED: begin
                        if (!matchReg) begin
                            if (lossCnt == LossLast) begin
                                state     <= RST_HOLD;
                                AlignDone <= 1'b0;
                                IntfRst   <= 1'b1;
                                SlipCnt   <= 4'd0;
                                RetryCnt  <= retrySat;
                                cycleCnt  <= 8'd0;
                            end else begin
                                lossCnt <= lossCnt + 8'd1;
                            end
                        end else begin
                            lossCnt <= 8'd0;
                        end
                    end
                    FAIL: begin
                        IntfRst   <= 1'b1;
                        AlignFail <= 1'b1;
                    end
                    default: begin
                        state     <= WAIT_LOCK;
                        IntfRst   <= 1'b1;
                        AlignDone <= 1'b0;
                        AlignFail <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
